// File: rtl/ex_stage.sv
// Execute stage: ID/EX register, operand forwarding, ALU, branch resolve, EX/MEM register.
// Define EX_MULT_EN to add a multi-cycle shift-add MUL (aluOP 10, funct 0x18).
module ex_stage #(
   parameter int XLEN       = 32,
   parameter int REG_ADDR_W = 5
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  id_valid,
   output logic                  ex_ready,
   input  logic [8:0]            id_ctl,
   input  logic [XLEN-1:0]       id_pc_plus4,
   input  logic [XLEN-1:0]       id_rs_data,
   input  logic [XLEN-1:0]       id_rt_data,
   input  logic [XLEN-1:0]       id_imm_sext,
   input  logic [REG_ADDR_W-1:0] id_rs,
   input  logic [REG_ADDR_W-1:0] id_rt,
   input  logic [REG_ADDR_W-1:0] id_rd,
   input  logic [5:0]            id_funct,
   input  logic                  mem_stall,
   input  logic                  fwd_mem_we,
   input  logic [REG_ADDR_W-1:0] fwd_mem_addr,
   input  logic [XLEN-1:0]       fwd_mem_data,
   input  logic                  fwd_wb_we,
   input  logic [REG_ADDR_W-1:0] fwd_wb_addr,
   input  logic [XLEN-1:0]       fwd_wb_data,
   output logic                  br_taken,
   output logic [XLEN-1:0]       br_target,
   output logic                  haz_memRead,
   output logic [REG_ADDR_W-1:0] haz_rt,
   output logic                  exm_valid,
   output logic [3:0]            exm_ctl,
   output logic [XLEN-1:0]       exm_alu,
   output logic [XLEN-1:0]       exm_wdata,
   output logic [REG_ADDR_W-1:0] exm_waddr
);

   // ctl bits: 8 regDst, 7 aluSrc, 6 memToReg, 5 regWrite, 4 memRead, 3 memWrite, 2 branch, 1:0 aluOP
   typedef struct packed {
      logic                  valid;
      logic [8:0]            ctl;
      logic [XLEN-1:0]       pc4;
      logic [XLEN-1:0]       rs_data;
      logic [XLEN-1:0]       rt_data;
      logic [XLEN-1:0]       imm;
      logic [REG_ADDR_W-1:0] rs;
      logic [REG_ADDR_W-1:0] rt;
      logic [REG_ADDR_W-1:0] rd;
      logic [5:0]            funct;
   } idex_t;

   idex_t                 idex_q, idex_d;
   logic                  exm_valid_q, exm_valid_d;
   logic [3:0]            exm_ctl_q, exm_ctl_d;
   logic [XLEN-1:0]       exm_alu_q, exm_alu_d;
   logic [XLEN-1:0]       exm_wdata_q, exm_wdata_d;
   logic [REG_ADDR_W-1:0] exm_waddr_q, exm_waddr_d;

   logic [XLEN-1:0]       fwd_rs, fwd_rt, alu_b, ex_result;
   logic                  mul_busy;

   function automatic logic [XLEN-1:0] alu_fn(input logic [1:0] op, input logic [5:0] funct,
                                              input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
      logic signed [XLEN-1:0] sa;
      logic signed [XLEN-1:0] sb;
      logic [XLEN-1:0]        r;
      sa = a;
      sb = b;
      r  = '0;
      case (op)
         2'b01: r = a - b;
         2'b10: begin
            case (funct)
               6'h20, 6'h21: r = a + b;
               6'h22, 6'h23: r = a - b;
               6'h24:        r = a & b;
               6'h25:        r = a | b;
               6'h26:        r = a ^ b;
               6'h27:        r = ~(a | b);
               6'h2A:        r = XLEN'(sa < sb);
               6'h2B:        r = XLEN'(a < b);
               default:      r = '0;
            endcase
         end
         default: r = a + b;
      endcase
      return r;
   endfunction

   // Register specifier 0 is hardwired zero and never takes a forwarded value; MEM beats WB.
   always_comb begin
      fwd_rs = idex_q.rs_data;
      if (idex_q.rs != '0 && fwd_mem_we && fwd_mem_addr == idex_q.rs)
         fwd_rs = fwd_mem_data;
      else if (idex_q.rs != '0 && fwd_wb_we && fwd_wb_addr == idex_q.rs)
         fwd_rs = fwd_wb_data;

      fwd_rt = idex_q.rt_data;
      if (idex_q.rt != '0 && fwd_mem_we && fwd_mem_addr == idex_q.rt)
         fwd_rt = fwd_mem_data;
      else if (idex_q.rt != '0 && fwd_wb_we && fwd_wb_addr == idex_q.rt)
         fwd_rt = fwd_wb_data;
   end

   assign alu_b       = idex_q.ctl[7] ? idex_q.imm : fwd_rt;
   assign ex_ready    = ~mem_stall & ~mul_busy;
   assign br_taken    = idex_q.valid & idex_q.ctl[2] & (fwd_rs == fwd_rt) & ex_ready;
   assign br_target   = idex_q.pc4 + (idex_q.imm << 2);
   assign haz_memRead = idex_q.valid & idex_q.ctl[4];
   assign haz_rt      = idex_q.rt;

`ifdef EX_MULT_EN
   localparam int CNT_W = $clog2(XLEN + 1);
   typedef enum logic [1:0] {IDLE, BUSY, DONE} mstate_e;

   mstate_e          state_q;
   logic [XLEN-1:0]  mcand_q, mplier_q, prod_q;
   logic [CNT_W-1:0] cnt_q;
   logic             is_mul;

   assign is_mul   = idex_q.valid && idex_q.ctl[1:0] == 2'b10 && idex_q.funct == 6'h18;
   assign mul_busy = (state_q == IDLE && is_mul) || state_q == BUSY;

   // One multiplier bit per BUSY cycle; DONE waits for EX/MEM to take the product.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         mcand_q  <= '0;
         mplier_q <= '0;
         prod_q   <= '0;
         cnt_q    <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (is_mul) begin
                  state_q  <= BUSY;
                  mcand_q  <= fwd_rs;
                  mplier_q <= alu_b;
                  prod_q   <= '0;
                  cnt_q    <= '0;
               end
            end
            BUSY: begin
               prod_q   <= prod_q + (mplier_q[0] ? mcand_q : '0);
               mcand_q  <= mcand_q << 1;
               mplier_q <= mplier_q >> 1;
               cnt_q    <= cnt_q + CNT_W'(1);
               if (cnt_q == CNT_W'(XLEN - 1))
                  state_q <= DONE;
            end
            DONE: begin
               if (!mem_stall)
                  state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   always_comb begin
      ex_result = alu_fn(idex_q.ctl[1:0], idex_q.funct, fwd_rs, alu_b);
      if (state_q == DONE)
         ex_result = prod_q;
   end
`else
   assign mul_busy  = 1'b0;
   assign ex_result = alu_fn(idex_q.ctl[1:0], idex_q.funct, fwd_rs, alu_b);
`endif

   // While stalled, operands keep absorbing forwarded results so a late writeback is not lost.
   always_comb begin
      idex_d = idex_q;
      if (ex_ready) begin
         idex_d.valid   = id_valid & ~br_taken;
         idex_d.ctl     = id_ctl;
         idex_d.pc4     = id_pc_plus4;
         idex_d.rs_data = id_rs_data;
         idex_d.rt_data = id_rt_data;
         idex_d.imm     = id_imm_sext;
         idex_d.rs      = id_rs;
         idex_d.rt      = id_rt;
         idex_d.rd      = id_rd;
         idex_d.funct   = id_funct;
      end else begin
         idex_d.rs_data = fwd_rs;
         idex_d.rt_data = fwd_rt;
      end
   end

   always_comb begin
      exm_valid_d = exm_valid_q;
      exm_ctl_d   = exm_ctl_q;
      exm_alu_d   = exm_alu_q;
      exm_wdata_d = exm_wdata_q;
      exm_waddr_d = exm_waddr_q;
      if (!mem_stall) begin
         exm_valid_d = idex_q.valid & ~mul_busy;
         exm_ctl_d   = exm_valid_d ? idex_q.ctl[6:3] : 4'b0;
         exm_alu_d   = ex_result;
         exm_wdata_d = fwd_rt;
         exm_waddr_d = idex_q.ctl[8] ? idex_q.rd : idex_q.rt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idex_q      <= '0;
         exm_valid_q <= 1'b0;
         exm_ctl_q   <= '0;
         exm_alu_q   <= '0;
         exm_wdata_q <= '0;
         exm_waddr_q <= '0;
      end else begin
         idex_q      <= idex_d;
         exm_valid_q <= exm_valid_d;
         exm_ctl_q   <= exm_ctl_d;
         exm_alu_q   <= exm_alu_d;
         exm_wdata_q <= exm_wdata_d;
         exm_waddr_q <= exm_waddr_d;
      end
   end

   assign exm_valid = exm_valid_q;
   assign exm_ctl   = exm_ctl_q;
   assign exm_alu   = exm_alu_q;
   assign exm_wdata = exm_wdata_q;
   assign exm_waddr = exm_waddr_q;

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed vector table, stall/branch/multiply sequences,
// and randomized single instructions checked against a behavioural model.
module tb_ex_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        id_valid;
   logic        ex_ready;
   logic [8:0]  id_ctl;
   logic [31:0] id_pc_plus4, id_rs_data, id_rt_data, id_imm_sext;
   logic [4:0]  id_rs, id_rt, id_rd;
   logic [5:0]  id_funct;
   logic        mem_stall;
   logic        fwd_mem_we, fwd_wb_we;
   logic [4:0]  fwd_mem_addr, fwd_wb_addr;
   logic [31:0] fwd_mem_data, fwd_wb_data;
   logic        br_taken;
   logic [31:0] br_target;
   logic        haz_memRead;
   logic [4:0]  haz_rt;
   logic        exm_valid;
   logic [3:0]  exm_ctl;
   logic [31:0] exm_alu, exm_wdata;
   logic [4:0]  exm_waddr;

   ex_stage #(.XLEN(32), .REG_ADDR_W(5)) dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .ex_ready(ex_ready), .id_ctl(id_ctl),
      .id_pc_plus4(id_pc_plus4), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
      .id_imm_sext(id_imm_sext), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_funct(id_funct),
      .mem_stall(mem_stall), .fwd_mem_we(fwd_mem_we), .fwd_mem_addr(fwd_mem_addr),
      .fwd_mem_data(fwd_mem_data), .fwd_wb_we(fwd_wb_we), .fwd_wb_addr(fwd_wb_addr),
      .fwd_wb_data(fwd_wb_data), .br_taken(br_taken), .br_target(br_target),
      .haz_memRead(haz_memRead), .haz_rt(haz_rt), .exm_valid(exm_valid), .exm_ctl(exm_ctl),
      .exm_alu(exm_alu), .exm_wdata(exm_wdata), .exm_waddr(exm_waddr)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [8:0]  ctl;
      logic [5:0]  funct;
      logic [4:0]  rs, rt, rd;
      logic [31:0] rs_data, rt_data, imm, pc4;
      logic        mwe;
      logic [4:0]  maddr;
      logic [31:0] mdata;
      logic        wwe;
      logic [4:0]  waddr;
      logic [31:0] wdata;
      logic [31:0] e_alu;
      logic [4:0]  e_waddr;
      logic [31:0] e_wdata;
      logic        e_br;
      logic [31:0] e_tgt;
   } vec_t;

   localparam logic [8:0] C_RTYPE = 9'b100100010;
   localparam logic [8:0] C_LW    = 9'b011110000;
   localparam logic [8:0] C_SW    = 9'b010001011;
   localparam logic [8:0] C_BEQ   = 9'b000000101;

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic drive(input vec_t v);
      id_ctl       = v.ctl;
      id_funct     = v.funct;
      id_rs        = v.rs;
      id_rt        = v.rt;
      id_rd        = v.rd;
      id_rs_data   = v.rs_data;
      id_rt_data   = v.rt_data;
      id_imm_sext  = v.imm;
      id_pc_plus4  = v.pc4;
      fwd_mem_we   = v.mwe;
      fwd_mem_addr = v.maddr;
      fwd_mem_data = v.mdata;
      fwd_wb_we    = v.wwe;
      fwd_wb_addr  = v.waddr;
      fwd_wb_data  = v.wdata;
   endtask

   // One instruction through the stage with forwarding inputs held for its EX cycle.
   task automatic run_vec(input string tag, input vec_t v);
      drive(v);
      id_valid = 1'b1;
      step();
      id_valid = 1'b0;
      #1;
      chk({tag, ".br_taken"}, 32'(br_taken), 32'(v.e_br));
      if (v.e_br) chk({tag, ".br_target"}, br_target, v.e_tgt);
      chk({tag, ".haz_memRead"}, 32'(haz_memRead), 32'(v.ctl[4]));
      chk({tag, ".haz_rt"}, 32'(haz_rt), 32'(v.rt));
      chk({tag, ".ex_ready"}, 32'(ex_ready), 32'd1);
      step();
      chk({tag, ".exm_valid"}, 32'(exm_valid), 32'd1);
      chk({tag, ".exm_ctl"}, 32'(exm_ctl), 32'(v.ctl[6:3]));
      chk({tag, ".exm_alu"}, exm_alu, v.e_alu);
      chk({tag, ".exm_wdata"}, exm_wdata, v.e_wdata);
      chk({tag, ".exm_waddr"}, 32'(exm_waddr), 32'(v.e_waddr));
   endtask

   // Behavioural reference: register-file view of forwarding and an arithmetic ALU.
   function automatic logic [31:0] ref_operand(input vec_t v, input logic [4:0] spec, input logic [31:0] stored);
      if (spec == 5'd0) return stored;
      if (v.mwe && v.maddr == spec) return v.mdata;
      if (v.wwe && v.waddr == spec) return v.wdata;
      return stored;
   endfunction

   function automatic logic [31:0] ref_alu(input logic [1:0] op, input logic [5:0] f,
                                           input logic [31:0] a, input logic [31:0] b);
      if (op == 2'b01) return a - b;
      if (op != 2'b10) return a + b;
      case (f)
         6'h20, 6'h21: return a + b;
         6'h22, 6'h23: return a - b;
         6'h24: return a & b;
         6'h25: return a | b;
         6'h26: return a ^ b;
         6'h27: return ~(a | b);
         6'h2A: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         6'h2B: return (a < b) ? 32'd1 : 32'd0;
         default: return 32'd0;
      endcase
   endfunction

   function automatic vec_t model(input vec_t v);
      vec_t        r;
      logic [31:0] a, brt, b;
      r       = v;
      a       = ref_operand(v, v.rs, v.rs_data);
      brt     = ref_operand(v, v.rt, v.rt_data);
      b       = v.ctl[7] ? v.imm : brt;
      r.e_alu   = ref_alu(v.ctl[1:0], v.funct, a, b);
      r.e_wdata = brt;
      r.e_waddr = v.ctl[8] ? v.rd : v.rt;
      r.e_br    = v.ctl[2] && (a == brt);
      r.e_tgt   = v.pc4 + v.imm * 32'd4;
      return r;
   endfunction

   vec_t vecs[14];
   logic [5:0] flist[11] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B, 6'h3F};

   initial begin
      vec_t v;
      int   low;

      //            ctl      funct  rs     rt     rd     rs_data        rt_data        imm            pc4            mwe   maddr  mdata        wwe   waddr  wdata        e_alu          e_waddr e_wdata       e_br  e_tgt
      vecs[0]  = '{C_RTYPE, 6'h20, 5'd1, 5'd2, 5'd3, 32'h99,        32'd7,         32'd0,         32'd0,         1'b1, 5'd1, 32'd5,        1'b0, 5'd0, 32'd0,        32'd12,        5'd3, 32'd7,         1'b0, 32'd0};
      vecs[1]  = '{C_RTYPE, 6'h20, 5'd1, 5'd2, 5'd4, 32'h33,        32'd0,         32'd0,         32'd0,         1'b1, 5'd1, 32'd10,       1'b1, 5'd1, 32'd20,       32'd10,        5'd4, 32'd0,         1'b0, 32'd0};
      vecs[2]  = '{C_RTYPE, 6'h20, 5'd0, 5'd2, 5'd5, 32'h44,        32'd1,         32'd0,         32'd0,         1'b1, 5'd0, 32'd9,        1'b1, 5'd0, 32'd8,        32'h45,        5'd5, 32'd1,         1'b0, 32'd0};
      vecs[3]  = '{C_RTYPE, 6'h22, 5'd6, 5'd7, 5'd8, 32'd100,       32'd1,         32'd0,         32'd0,         1'b0, 5'd7, 32'd0,        1'b1, 5'd7, 32'd30,       32'd70,        5'd8, 32'd30,        1'b0, 32'd0};
      vecs[4]  = '{C_RTYPE, 6'h2A, 5'd1, 5'd2, 5'd3, 32'hFFFFFFFF,  32'd1,         32'd0,         32'd0,         1'b0, 5'd0, 32'd0,        1'b0, 5'd0, 32'd0,        32'd1,         5'd3, 32'd1,         1'b0, 32'd0};
      vecs[5]  = '{C_RTYPE, 6'h2B, 5'd1, 5'd2, 5'd3, 32'hFFFFFFFF,  32'd1,         32'd0,         32'd0,         1'b0, 5'd0, 32'd0,        1'b0, 5'd0, 32'd0,        32'd0,         5'd3, 32'd1,         1'b0, 32'd0};
      vecs[6]  = '{C_RTYPE, 6'h20, 5'd1, 5'd2, 5'd3, 32'hFFFFFFFF,  32'd1,         32'd0,         32'd0,         1'b0, 5'd0, 32'd0,        1'b0, 5'd0, 32'd0,        32'd0,         5'd3, 32'd1,         1'b0, 32'd0};
      vecs[7]  = '{C_RTYPE, 6'h24, 5'd1, 5'd2, 5'd3, 32'hF0F0F0F0,  32'h0FF00FF0,  32'd0,         32'd0,         1'b0, 5'd0, 32'd0,        1'b0, 5'd0, 32'd0,        32'h00F000F0,  5'd3, 32'h0FF00FF0,  1'b0, 32'd0};
      vecs[8]  = '{C_RTYPE, 6'h27, 5'd1, 5'd2, 5'd3, 32'hF0F0F0F0,  32'h0F0F0000,  32'd0,         32'd0,         1'b0, 5'd0, 32'd0,        1'b0, 5'd0, 32'd0,        32'h00000F0F,  5'd3, 32'h0F0F0000,  1'b0, 32'd0};
      vecs[9]  = '{C_RTYPE, 6'h26, 5'd1, 5'd2, 5'd3, 32'h12345678,  32'hFFFF0000,  32'd0,         32'd0,         1'b0, 5'd0, 32'd0,        1'b0, 5'd0, 32'd0,        32'hEDCB5678,  5'd3, 32'hFFFF0000,  1'b0, 32'd0};
      vecs[10] = '{C_RTYPE, 6'h3F, 5'd1, 5'd2, 5'd3, 32'd5,         32'd6,         32'd0,         32'd0,         1'b0, 5'd0, 32'd0,        1'b0, 5'd0, 32'd0,        32'd0,         5'd3, 32'd6,         1'b0, 32'd0};
      vecs[11] = '{C_LW,    6'h00, 5'd1, 5'd9, 5'd3, 32'h1000,      32'h55,        32'hFFFFFFFC,  32'd0,         1'b0, 5'd0, 32'd0,        1'b0, 5'd0, 32'd0,        32'h00000FFC,  5'd9, 32'h55,        1'b0, 32'd0};
      vecs[12] = '{C_SW,    6'h00, 5'd1, 5'd9, 5'd3, 32'h20,        32'h77,        32'd8,         32'd0,         1'b0, 5'd0, 32'd0,        1'b0, 5'd0, 32'd0,        32'h28,        5'd9, 32'h77,        1'b0, 32'd0};
      vecs[13] = '{C_BEQ,   6'h00, 5'd4, 5'd5, 5'd0, 32'd4,         32'd5,         32'd3,         32'h100,       1'b0, 5'd0, 32'd0,        1'b0, 5'd0, 32'd0,        32'hFFFFFFFF,  5'd5, 32'd5,         1'b0, 32'h10C};

      rst_n = 1'b0;
      id_valid = 1'b0;
      mem_stall = 1'b0;
      drive(vecs[10]);
      #12;
      chk("reset.exm_valid", 32'(exm_valid), 32'd0);
      chk("reset.exm_ctl", 32'(exm_ctl), 32'd0);
      chk("reset.exm_alu", exm_alu, 32'd0);
      chk("reset.br_taken", 32'(br_taken), 32'd0);
      chk("reset.haz_memRead", 32'(haz_memRead), 32'd0);
      chk("reset.ex_ready", 32'(ex_ready), 32'd1);
      rst_n = 1'b1;
      step();

      for (int i = 0; i < 14; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

      // Taken branch squashes the instruction that follows it in ID.
      v = vecs[13];
      v.rt_data = 32'd4;
      drive(v);
      id_valid = 1'b1;
      step();
      v = vecs[11];
      drive(v);
      #1;
      chk("beq.br_taken", 32'(br_taken), 32'd1);
      chk("beq.br_target", br_target, 32'h10C);
      step();
      id_valid = 1'b0;
      #1;
      chk("beq.squash_br", 32'(br_taken), 32'd0);
      chk("beq.squash_haz", 32'(haz_memRead), 32'd0);
      chk("beq.exm_valid", 32'(exm_valid), 32'd1);
      step();
      chk("beq.bubble", 32'(exm_valid), 32'd0);

      // SUB held three cycles by mem_stall; WB result for rt visible only in the first.
      v = vecs[6];
      v.rs_data = 32'd1; v.rt_data = 32'd2; v.rd = 5'd10;
      drive(v);
      id_valid = 1'b1;
      step();
      v.funct = 6'h22; v.rs_data = 32'd50; v.rt_data = 32'd8; v.rd = 5'd3;
      drive(v);
      step();
      id_valid = 1'b0;
      mem_stall = 1'b1;
      fwd_wb_we = 1'b1; fwd_wb_addr = 5'd2; fwd_wb_data = 32'd3;
      #1;
      for (int c = 0; c < 3; c++) begin
         chk($sformatf("stall%0d.ex_ready", c), 32'(ex_ready), 32'd0);
         chk($sformatf("stall%0d.exm_alu", c), exm_alu, 32'd3);
         chk($sformatf("stall%0d.exm_waddr", c), 32'(exm_waddr), 32'd10);
         step();
         fwd_wb_we = 1'b0;
      end
      mem_stall = 1'b0;
      step();
      chk("stall.exm_alu", exm_alu, 32'd47);
      chk("stall.exm_wdata", exm_wdata, 32'd3);
      chk("stall.exm_waddr", 32'(exm_waddr), 32'd3);

      // MUL 0xFFFF * 0x10001
      v = vecs[6];
      v.funct = 6'h18; v.rs_data = 32'h0000FFFF; v.rt_data = 32'h00010001; v.rd = 5'd7;
      drive(v);
      id_valid = 1'b1;
      step();
      id_valid = 1'b0;
`ifdef EX_MULT_EN
      low = 0;
      while (!ex_ready && low < 100) begin
         low++;
         step();
      end
      chk("mul.busy_cycles", 32'(low), 32'd33);
      chk("mul.bubble", 32'(exm_valid), 32'd0);
      step();
      chk("mul.exm_valid", 32'(exm_valid), 32'd1);
      chk("mul.exm_alu", exm_alu, 32'hFFFFFFFF);
      chk("mul.exm_waddr", 32'(exm_waddr), 32'd7);
      drive(v);
      id_valid = 1'b1;
      step();
      id_valid = 1'b0;
      repeat (10) step();
      chk("mulrst.busy", 32'(ex_ready), 32'd0);
      rst_n = 1'b0;
      #1;
      chk("mulrst.exm_valid", 32'(exm_valid), 32'd0);
      chk("mulrst.ex_ready", 32'(ex_ready), 32'd1);
      rst_n = 1'b1;
      repeat (40) step();
      chk("mulrst.no_result", 32'(exm_valid), 32'd0);
`else
      low = 0;
      #1;
      chk("mul.ex_ready", 32'(ex_ready), 32'd1);
      step();
      chk("mul.exm_valid", 32'(exm_valid), 32'd1);
      chk("mul.exm_alu", exm_alu, 32'd0 + 32'(low));
`endif

      for (int t = 0; t < 150; t++) begin
         v.ctl     = 9'($urandom);
         v.funct   = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 15)) : flist[$urandom_range(0, 10)];
         v.rs      = 5'($urandom_range(0, 3));
         v.rt      = 5'($urandom_range(0, 3));
         v.rd      = 5'($urandom);
         v.rs_data = $urandom;
         v.rt_data = ($urandom_range(0, 1) == 1) ? v.rs_data : $urandom;
         v.imm     = $urandom;
         v.pc4     = $urandom;
         v.mwe     = 1'($urandom);
         v.maddr   = 5'($urandom_range(0, 3));
         v.mdata   = $urandom;
         v.wwe     = 1'($urandom);
         v.waddr   = 5'($urandom_range(0, 3));
         v.wdata   = ($urandom_range(0, 3) == 0) ? v.mdata : $urandom;
         v = model(v);
         run_vec($sformatf("rnd%0d", t), v);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width.
REQ-002 SHALL have parameter REG_ADDR_W, default 5, register-address width.
REQ-003 SHALL have port clk  in  1  sole clock, rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port id_valid  in  1  ID presents an instruction.
REQ-006 SHALL have port ex_ready  out  1  ID/EX accepts this cycle.
REQ-007 SHALL have port id_ctl  in  9  {regDst,aluSrc,memToReg,regWrite,memRead,memWrite,branch,aluOP1,aluOP0}.
REQ-008 SHALL have ports id_pc_plus4, id_rs_data, id_rt_data, id_imm_sext  in  XLEN each  ID operands.
REQ-009 SHALL have ports id_rs, id_rt, id_rd  in  REG_ADDR_W each  register specifiers.
REQ-010 SHALL have port id_funct  in  6  R-type function field.
REQ-011 SHALL have port mem_stall  in  1  MEM cannot accept.
REQ-012 SHALL have ports fwd_mem_we/fwd_mem_addr/fwd_mem_data  in  1/REG_ADDR_W/XLEN  MEM-stage result.
REQ-013 SHALL have ports fwd_wb_we/fwd_wb_addr/fwd_wb_data  in  1/REG_ADDR_W/XLEN  WB-stage result.
REQ-014 SHALL have ports br_taken  out  1  and br_target  out  XLEN  branch redirect.
REQ-015 SHALL have ports haz_memRead  out  1  and haz_rt  out  REG_ADDR_W  ID/EX load info for load-use detection.
REQ-016 SHALL have ports exm_valid  out  1, exm_ctl  out  4 {memToReg,regWrite,memRead,memWrite}, exm_alu  out  XLEN, exm_wdata  out  XLEN, exm_waddr  out  REG_ADDR_W  EX/MEM register.

Function
REQ-017 ex_ready SHALL equal !mem_stall AND multiplier not busy (REQ-029).
REQ-018 When ex_ready=1, ID/EX SHALL load all id_* fields with valid=id_valid; when br_taken=1 it SHALL load valid=0 regardless of id_valid.
REQ-019 When ex_ready=0, ID/EX SHALL hold, except that its rs/rt operand fields SHALL be rewritten each cycle with the forwarded values (REQ-020).
REQ-020 Forwarded operand SHALL be fwd_mem_data if fwd_mem_we and fwd_mem_addr==specifier; else fwd_wb_data on WB match; else the stored value. MEM has priority. Specifier 0 SHALL never forward.
REQ-021 ALU B SHALL be id_imm_sext field if aluSrc, else forwarded rt; exm_wdata SHALL be forwarded rt; exm_waddr SHALL be rd if regDst, else rt.
REQ-022 aluOP 00 or 11: add; 01: sub; 10: funct 0x20/0x21 add, 0x22/0x23 sub, 0x24 and, 0x25 or, 0x26 xor, 0x27 nor, 0x2A slt signed, 0x2B sltu; other funct: result 0.
REQ-023 Add/sub SHALL wrap modulo 2^XLEN; no overflow trap.
REQ-024 br_taken SHALL be 1 iff ID/EX valid, branch=1, forwarded rs==rt, ex_ready=1; br_target = pc_plus4 + (imm_sext<<2), wrapping.
REQ-025 EX/MEM SHALL load when !mem_stall and hold when mem_stall; latency one cycle (instruction entering ID/EX at edge N appears at exm_* after edge N+1).
REQ-026 exm_valid=0 SHALL force exm_ctl=0; haz_memRead SHALL equal ID/EX valid AND memRead.

Reset
REQ-027 rst_n low SHALL immediately clear ID/EX and EX/MEM valid, control and data to 0, FSM to IDLE; br_taken, haz_memRead, exm_valid read 0.
REQ-028 Reset mid-multiply SHALL abort it; no result is produced.

Configuration
REQ-029 With EX_MULT_EN defined, aluOP 10 funct 0x18 SHALL be MUL (low XLEN bits of product into rd) via shift-add FSM IDLE->BUSY (XLEN steps)->DONE->IDLE; ex_ready=0 in IDLE-with-MUL and BUSY (XLEN+1 cycles), EX/MEM receives bubbles, DONE holds under mem_stall and exits on EX/MEM capture.
REQ-030 Without EX_MULT_EN, funct 0x18 SHALL yield 0 in one cycle and no FSM SHALL exist.

Verification
REQ-031 ADD r3,r1,r2; fwd_mem r1=5, id_rt_data=7 -> next cycle exm_alu=12, exm_waddr=3, exm_valid=1.
REQ-032 MEM r1=10 and WB r1=20 both match -> operand 10; fwd_mem_addr=0 with data 9 -> operand id_rs_data.
REQ-033 BEQ rs=rt=4, imm=3, pc_plus4=0x100 -> br_taken 1 for one cycle, br_target=0x10C, following ID/EX valid=0 despite id_valid=1.
REQ-034 SUB held by mem_stall for 3 cycles, WB forward present only cycle 1 -> ex_ready=0, exm held, released result uses WB value.
REQ-035 A=0xFFFFFFFF, B=1 -> slt 1, sltu 0; add 0xFFFFFFFF+1 -> 0.
REQ-036 EX_MULT_EN: MUL 0xFFFF*0x10001 -> ex_ready low 33 cycles, then exm_alu=0xFFFFFFFF; undefined macro -> exm_alu=0 after one cycle.
